ultrasonic_scheduler: RTL and testbench

Sequences the ultrasonic ranging core: issues measurement starts, detects echo completion, and enforces a minimum ping interval and an echo-timeout watchdog. Captures the core's 32-bit echo cycle count and publishes a (optionally averaged) result with a valid strobe. Sits between the application FSM and the ultrasonic ranging core.

---
 rtl/ultrasonic_scheduler_pkg.sv | 23 ++
 rtl/ultrasonic_scheduler_if.sv | 13 +
 rtl/ultrasonic_scheduler_avg.sv | 60 ++++++
 rtl/ultrasonic_scheduler.sv | 160 ++++++++++++++++
 tb/tb_ultrasonic_scheduler.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ultrasonic_scheduler_pkg.sv
// Shared types and constants for the ultrasonic ranging scheduler.
// Optional averaging is selected with the ULTRASONIC_AVG_EN macro.
package ultrasonic_scheduler_pkg;

  localparam int unsigned COUNT_W            = 32'd32;
  localparam int unsigned ERR_W              = 32'd8;
  localparam int unsigned DEF_PERIOD_CYCLES  = 32'd3_000_000;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 32'd1_500_000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_HOLDOFF = 3'd5
  } state_t;

  function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
    return (v == {ERR_W{1'b1}}) ? v : v + ERR_W'(1'b1);
  endfunction

endpackage

// File: rtl/ultrasonic_scheduler_if.sv
// Handshake between the scheduler (master) and the ultrasonic ranging core (slave).
interface ultrasonic_scheduler_if;
  import ultrasonic_scheduler_pkg::*;

  logic               us_ready_o;
  logic               us_trigger_i;
  logic               us_echo_i;
  logic [COUNT_W-1:0] us_count_i;

  modport master (output us_ready_o, input us_trigger_i, input us_echo_i, input us_count_i);
  modport slave  (input us_ready_o, output us_trigger_i, output us_echo_i, output us_count_i);

endinterface

// File: rtl/ultrasonic_scheduler_avg.sv
// Block averager for captured echo counts; only built when ULTRASONIC_AVG_EN is defined.
`ifdef ULTRASONIC_AVG_EN
module ultrasonic_avg
  import ultrasonic_scheduler_pkg::*;
#(
  parameter int unsigned AVG_LOG2 = 32'd2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_valid,
  input  logic [COUNT_W-1:0] sample,
  input  logic               discard,
  output logic [COUNT_W-1:0] avg,
  output logic               avg_valid
);

  localparam int unsigned ACC_W      = 32'd36;
  localparam logic [4:0]  BLOCK_LAST = 5'((32'd1 << AVG_LOG2) - 32'd1);

  logic [ACC_W-1:0]   acc_r;
  logic [4:0]         n_r;
  logic [COUNT_W-1:0] avg_r;
  logic               avg_valid_r;
  logic [ACC_W-1:0]   sum_s;
  logic [ACC_W-1:0]   shift_s;

  assign sum_s     = acc_r + {{(ACC_W-COUNT_W){1'b0}}, sample};
  assign shift_s   = sum_s >> AVG_LOG2;
  assign avg       = avg_r;
  assign avg_valid = avg_valid_r;

  // Accumulate one block of samples, publish its mean, drop partial blocks on discard
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r       <= '0;
      n_r         <= 5'd0;
      avg_r       <= '0;
      avg_valid_r <= 1'b0;
    end else if (discard) begin
      acc_r       <= '0;
      n_r         <= 5'd0;
      avg_valid_r <= 1'b0;
    end else if (sample_valid) begin
      if (n_r == BLOCK_LAST) begin
        avg_r       <= shift_s[COUNT_W-1:0];
        avg_valid_r <= 1'b1;
        acc_r       <= '0;
        n_r         <= 5'd0;
      end else begin
        acc_r       <= sum_s;
        n_r         <= n_r + 5'd1;
        avg_valid_r <= 1'b0;
      end
    end else begin
      avg_valid_r <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/ultrasonic_scheduler.sv
// Ping sequencer for the ultrasonic ranging core: start, echo wait, capture, timeout, holdoff.
// Define ULTRASONIC_AVG_EN to publish block averages instead of every capture.
module ultrasonic_scheduler
  import ultrasonic_scheduler_pkg::*;
#(
  parameter int unsigned PERIOD_CYCLES  = DEF_PERIOD_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
`ifdef ULTRASONIC_AVG_EN
  parameter int unsigned AVG_LOG2       = 32'd2,
`endif
  parameter int unsigned HOLD_W         = COUNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable_i,
  input  logic                  single_i,
  ultrasonic_scheduler_if.master core,
  output logic [COUNT_W-1:0]    dist_o,
  output logic                  dist_valid_o,
  output logic                  timeout_o,
  output logic                  busy_o,
  output logic [ERR_W-1:0]      err_cnt_o
);

  // Counter value on the last cycle before timeout / end of holdoff
  localparam logic [HOLD_W-1:0] TO_LAST  = HOLD_W'(TIMEOUT_CYCLES - 32'd1);
  localparam logic [HOLD_W-1:0] PER_LAST = HOLD_W'(PERIOD_CYCLES - 32'd1);
  localparam logic [HOLD_W-1:0] CNT_MAX  = {HOLD_W{1'b1}};

  state_t             state_r;
  state_t             state_s;
  logic [HOLD_W-1:0]  cnt_r;
  logic               measuring_s;
  logic               timeout_s;
  logic               start_s;
  logic               ready_s;
  logic               busy_s;
  logic               capture_s;
  logic               us_ready_r;
  logic               busy_r;
  logic               timeout_r;
  logic [ERR_W-1:0]   err_cnt_r;

  assign measuring_s = (state_r == ST_START) || (state_r == ST_WAIT_HI) || (state_r == ST_WAIT_LO);
  assign timeout_s   = measuring_s && (cnt_r >= TO_LAST);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; timeout takes priority over any core event in the same cycle
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (single_i || enable_i) state_s = ST_START;
        else                      state_s = ST_IDLE;
      end
      ST_START: begin
        if (timeout_s)              state_s = ST_HOLDOFF;
        else if (core.us_trigger_i) state_s = ST_WAIT_HI;
        else                        state_s = ST_START;
      end
      ST_WAIT_HI: begin
        if (timeout_s)           state_s = ST_HOLDOFF;
        else if (core.us_echo_i) state_s = ST_WAIT_LO;
        else                     state_s = ST_WAIT_HI;
      end
      ST_WAIT_LO: begin
        if (timeout_s)            state_s = ST_HOLDOFF;
        else if (!core.us_echo_i) state_s = ST_CAPTURE;
        else                      state_s = ST_WAIT_LO;
      end
      ST_CAPTURE: state_s = ST_HOLDOFF;
      ST_HOLDOFF: begin
        if (cnt_r >= PER_LAST) state_s = enable_i ? ST_START : ST_IDLE;
        else                   state_s = ST_HOLDOFF;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Output decode from the next state so the output registers line up with the state
  always_comb begin
    ready_s   = (state_s == ST_START);
    busy_s    = (state_s != ST_IDLE);
    capture_s = (state_r == ST_CAPTURE);
    start_s   = (state_s == ST_START) && (state_r != ST_START);
  end

  // Start-to-start counter: restarts on every entry to START, saturates at all ones
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if (start_s) begin
      cnt_r <= '0;
    end else if (cnt_r != CNT_MAX) begin
      cnt_r <= cnt_r + HOLD_W'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Handshake, status and error-count output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      us_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      timeout_r  <= 1'b0;
      err_cnt_r  <= '0;
    end else begin
      us_ready_r <= ready_s;
      busy_r     <= busy_s;
      timeout_r  <= timeout_s;
      err_cnt_r  <= timeout_s ? sat_inc_err(err_cnt_r) : err_cnt_r;
    end
  end

  assign core.us_ready_o = us_ready_r;
  assign busy_o          = busy_r;
  assign timeout_o       = timeout_r;
  assign err_cnt_o       = err_cnt_r;

`ifdef ULTRASONIC_AVG_EN
  ultrasonic_avg #(
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (capture_s),
    .sample       (core.us_count_i),
    .discard      (timeout_s),
    .avg          (dist_o),
    .avg_valid    (dist_valid_o)
  );
`else
  logic [COUNT_W-1:0] dist_r;
  logic               dist_valid_r;

  // Publish every capture directly
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dist_r       <= '0;
      dist_valid_r <= 1'b0;
    end else begin
      dist_r       <= capture_s ? core.us_count_i : dist_r;
      dist_valid_r <= capture_s;
    end
  end

  assign dist_o       = dist_r;
  assign dist_valid_o = dist_valid_r;
`endif

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// Randomised bench for ultrasonic_scheduler with a core model and an event-level reference.
// Follows ULTRASONIC_AVG_EN to choose the averaging block size of the reference.
module tb_ultrasonic_scheduler;
  import ultrasonic_scheduler_pkg::*;

  localparam int PER = 120;
  localparam int TMO = 80;
`ifdef ULTRASONIC_AVG_EN
  localparam int BLK = 4;
`else
  localparam int BLK = 1;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               enable_i = 1'b0;
  logic               single_i = 1'b0;
  logic [COUNT_W-1:0] dist_o;
  logic               dist_valid_o;
  logic               timeout_o;
  logic               busy_o;
  logic [ERR_W-1:0]   err_cnt_o;

  ultrasonic_scheduler_if core_if ();

  ultrasonic_scheduler #(
    .PERIOD_CYCLES  (PER),
    .TIMEOUT_CYCLES (TMO),
    .HOLD_W         (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable_i     (enable_i),
    .single_i     (single_i),
    .core         (core_if),
    .dist_o       (dist_o),
    .dist_valid_o (dist_valid_o),
    .timeout_o    (timeout_o),
    .busy_o       (busy_o),
    .err_cnt_o    (err_cnt_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference model: block averages of completed echoes, timeouts drop partial blocks
  int blk_sum = 0;
  int blk_n   = 0;
  int exp_q[$];
  int last_dist = 0;
  int exp_err   = 0;
  int epoch     = 0;

  function automatic void model_sample(input int v);
    blk_sum += v;
    blk_n++;
    if (blk_n == BLK) begin
      exp_q.push_back(blk_sum / BLK);
      blk_sum = 0;
      blk_n   = 0;
    end
  endfunction

  function automatic void model_timeout();
    blk_sum = 0;
    blk_n   = 0;
    if (exp_err < 255) exp_err++;
  endfunction

  function automatic void model_reset();
    blk_sum = 0;
    blk_n   = 0;
    exp_q.delete();
    last_dist = 0;
    exp_err   = 0;
    epoch++;
  endfunction

  // Core model: mode 0 normal echo, 1 trigger but no echo, 2 never trigger
  int mode      = 0;
  int fixed_len = 50;
  bit core_busy = 1'b0;

  initial begin
    int my_epoch;
    int len;
    int m;
    core_if.us_trigger_i = 1'b0;
    core_if.us_echo_i    = 1'b0;
    core_if.us_count_i   = '0;
    forever begin
      @(negedge clk);
      if (rst && core_if.us_ready_o) begin
        my_epoch  = epoch;
        m         = mode;
        core_busy = 1'b1;
        if (m == 2) begin
          model_timeout();
          for (int k = 0; k < TMO + 10 && core_if.us_ready_o; k++) @(negedge clk);
        end else begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          core_if.us_trigger_i = 1'b1;
          @(negedge clk);
          core_if.us_trigger_i = 1'b0;
          core_if.us_count_i   = '0;
          if (m == 1) begin
            model_timeout();
          end else begin
            len = (fixed_len != 0) ? fixed_len : int'($urandom_range(1, 55));
            repeat ($urandom_range(1, 4)) @(negedge clk);
            core_if.us_echo_i = 1'b1;
            repeat (len) begin
              @(negedge clk);
              core_if.us_count_i = core_if.us_count_i + 32'd1;
            end
            core_if.us_echo_i = 1'b0;
            if (my_epoch == epoch) model_sample(len);
          end
        end
        core_busy = 1'b0;
      end
    end
  end

  // Output monitor: ping spacing, result values, timeout latency and strobe widths
  int rise_cnt    = 0;
  int last_rise   = 0;
  bit prev_ready  = 1'b0;
  bit prev_valid  = 1'b0;
  bit prev_to     = 1'b0;
  bit have_prev   = 1'b0;
  bit chk_spacing = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      prev_ready = 1'b0;
      prev_valid = 1'b0;
      prev_to    = 1'b0;
    end else begin
      if (core_if.us_ready_o && !prev_ready) begin
        if (chk_spacing && have_prev) check_eq("ping_spacing", cyc - last_rise, PER);
        rise_cnt++;
        last_rise = cyc;
        have_prev = 1'b1;
      end
      if (dist_valid_o) begin
        check_eq("valid_width", prev_valid, 0);
        check_eq("valid_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          last_dist = exp_q.pop_front();
          check_eq("dist", dist_o, last_dist);
        end
      end
      if (timeout_o) begin
        check_eq("timeout_width", prev_to, 0);
        check_eq("timeout_latency", cyc - last_rise, TMO);
        check_eq("err_cnt", err_cnt_o, exp_err);
        check_eq("dist_hold", dist_o, last_dist);
      end
      prev_ready = core_if.us_ready_o;
      prev_valid = dist_valid_o;
      prev_to    = timeout_o;
    end
  end

  task automatic pulse_single();
    @(negedge clk);
    single_i = 1'b1;
    @(negedge clk);
    single_i = 1'b0;
  endtask

  task automatic wait_idle(input int bound, input string tag);
    int n = 0;
    while ((busy_o || core_busy) && n < bound) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_idle"}, n < bound, 1);
  endtask

  task automatic wait_rises(input int target, input int bound, input string tag);
    int n = 0;
    while (rise_cnt < target && n < bound) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_rises"}, n < bound, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, core_if.us_ready_o, 0);
    check_eq({tag, "_busy"}, busy_o, 0);
    check_eq({tag, "_dist"}, dist_o, 0);
    check_eq({tag, "_valid"}, dist_valid_o, 0);
    check_eq({tag, "_timeout"}, timeout_o, 0);
    check_eq({tag, "_err"}, err_cnt_o, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int r0;
  int lens[4] = '{10, 20, 30, 40};

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    // one measurement, fixed echo length
    mode = 0; fixed_len = 50; r0 = rise_cnt;
    pulse_single();
    check_eq("single_busy", busy_o, 1);
    wait_idle(400, "single");
    check_eq("single_pings", rise_cnt - r0, 1);
    check_eq("single_dist", dist_o, last_dist);
    check_eq("single_pending", exp_q.size(), 0);

    // single while busy is ignored, both mid-echo and in holdoff
    r0 = rise_cnt;
    pulse_single();
    repeat (10) @(negedge clk);
    check_eq("busy_mid", busy_o, 1);
    pulse_single();
    repeat (90) @(negedge clk);
    check_eq("busy_holdoff", busy_o, 1);
    pulse_single();
    wait_idle(400, "ignored");
    check_eq("ignored_pings", rise_cnt - r0, 1);

    // random echo lengths
    fixed_len = 0;
    for (int i = 0; i < 6; i++) begin
      pulse_single();
      wait_idle(400, "rand");
    end

    // continuous mode, spacing checked by the monitor
    have_prev = 1'b0; chk_spacing = 1'b1; r0 = rise_cnt;
    @(negedge clk);
    enable_i = 1'b1;
    wait_rises(r0 + 8, 8 * PER + 200, "cont");
    enable_i = 1'b0;
    wait_idle(400, "cont");
    chk_spacing = 1'b0;
    check_eq("cont_pings", rise_cnt - r0, 8);
    check_eq("cont_pending", exp_q.size(), 0);

    // echo never rises, then trigger never comes
    mode = 1;
    pulse_single();
    wait_idle(400, "to_echo");
    mode = 2;
    pulse_single();
    wait_idle(400, "to_trig");
    check_eq("err_two", err_cnt_o, 2);

    // saturate the error counter
    mode = 1; r0 = rise_cnt;
    @(negedge clk);
    enable_i = 1'b1;
    wait_rises(r0 + 256, 256 * PER + 500, "sat");
    enable_i = 1'b0;
    wait_idle(400, "sat");
    check_eq("err_saturated", err_cnt_o, 255);

    // directed block of four echoes
    mode = 0;
    for (int i = 0; i < 4; i++) begin
      fixed_len = lens[i];
      pulse_single();
      wait_idle(400, "block");
    end
`ifdef ULTRASONIC_AVG_EN
    check_eq("block_dist", dist_o, 25);
`else
    check_eq("block_dist", dist_o, 40);
`endif

    // asynchronous reset while waiting for echo fall
    fixed_len = 50;
    pulse_single();
    for (int k = 0; k < 50 && !core_if.us_echo_i; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    check_eq("pre_rst_busy", busy_o, 1);
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    for (int k = 0; k < 100 && core_busy; k++) @(negedge clk);
    check_eq("midrst_core_done", core_busy, 0);
    rst = 1'b1;
    @(negedge clk);
    fixed_len = 33;
    pulse_single();
    wait_idle(400, "after_rst");
`ifdef ULTRASONIC_AVG_EN
    check_eq("after_rst_dist", dist_o, 0);
`else
    check_eq("after_rst_dist", dist_o, 33);
`endif
    check_eq("after_rst_err", err_cnt_o, 0);
    check_eq("final_pending", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
